// File: rtl/sram_cache_front.sv
// sram_cache_front: request front-end for one sram_cache array.
// After reset (and on flush) it walks every word writing INIT_VALUE; outside
// a walk it forwards single client requests with a same-cycle grant and
// returns read data with a valid strobe one cycle later.
// Optional feature: define SRAM_CACHE_FRONT_PARITY_EN to store even parity in
// sram_wuser_o[0] on writes and flag read parity errors on par_err_o.
// Handshake: cl_gnt_o is combinational from cl_req_i; a request is transferred
// in every cycle where cl_req_i && cl_gnt_o; cl_rvalid_o follows a granted
// read by exactly one cycle.
module sram_cache_front #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int NUM_WORDS  = 1024,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int AW = $clog2(NUM_WORDS),
    localparam int BW = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  init_done_o,
    input  logic                  cl_req_i,
    output logic                  cl_gnt_o,
    input  logic                  cl_we_i,
    input  logic [AW-1:0]         cl_addr_i,
    input  logic [DATA_WIDTH-1:0] cl_wdata_i,
    input  logic [BW-1:0]         cl_be_i,
    output logic                  cl_rvalid_o,
    output logic [DATA_WIDTH-1:0] cl_rdata_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic [USER_WIDTH-1:0] sram_wuser_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [BW-1:0]         sram_be_o,
`ifdef SRAM_CACHE_FRONT_PARITY_EN
    output logic                  par_err_o,
`endif
    input  logic [USER_WIDTH-1:0] sram_ruser_i,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    localparam logic [0:0] S_WALK = 1'b0;
    localparam logic [0:0] S_IDLE = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          flush_pend_q, flush_pend_d;
    logic          init_done_q, init_done_d;
    logic          rvalid_q, rvalid_d;
    logic          walk, last_word, gnt;
    logic          unused_ruser;

    assign walk      = (state_q == S_WALK);
    assign last_word = (cnt_q == AW'(NUM_WORDS - 1));
    // Flush (requested now or left pending from a walk) wins over a client.
    assign gnt       = !rst_i && !walk && !flush_i && !flush_pend_q && cl_req_i;

    assign cl_gnt_o    = gnt;
    assign busy_o      = walk || rst_i;
    assign init_done_o = init_done_q && !rst_i;
    assign cl_rvalid_o = rvalid_q && !rst_i;
    assign cl_rdata_o  = sram_rdata_i;
    assign sram_req_o  = !rst_i && (walk || gnt);
    // Upper user bits are never consumed; bit 0 only with parity enabled.
    assign unused_ruser = ^sram_ruser_i;

`ifdef SRAM_CACHE_FRONT_PARITY_EN
    logic [DATA_WIDTH-1:0] wmask;

    // Expand byte enables to a bit mask so parity covers only written bytes.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            wmask[i] = cl_be_i[i / 8];
        end
    end

    assign par_err_o = cl_rvalid_o && ((^sram_rdata_i) ^ sram_ruser_i[0]);
`endif

    // SRAM command mux: walk writes own the array, otherwise mirror the client.
    always_comb begin
        sram_wuser_o = '0;
        if (walk) begin
            sram_we_o    = 1'b1;
            sram_addr_o  = cnt_q;
            sram_wdata_o = INIT_VALUE;
            sram_be_o    = '1;
`ifdef SRAM_CACHE_FRONT_PARITY_EN
            sram_wuser_o[0] = ^INIT_VALUE;
`endif
        end else begin
            sram_we_o    = cl_we_i;
            sram_addr_o  = cl_addr_i;
            sram_wdata_o = cl_wdata_i;
            sram_be_o    = cl_be_i;
`ifdef SRAM_CACHE_FRONT_PARITY_EN
            sram_wuser_o[0] = ^(cl_wdata_i & wmask);
`endif
        end
    end

    // Next-state logic for the walk/idle controller and the read strobe.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        init_done_d  = init_done_q;
        rvalid_d     = gnt && !cl_we_i;
        if (walk) begin
            cnt_d = cnt_q + AW'(1);
            if (flush_i) begin
                flush_pend_d = 1'b1;
            end
            if (last_word) begin
                cnt_d        = '0;
                init_done_d  = 1'b1;
                flush_pend_d = 1'b0;
                // A flush seen during this walk chains a fresh walk.
                state_d      = (flush_pend_q || flush_i) ? S_WALK : S_IDLE;
            end
        end else if (flush_i || flush_pend_q) begin
            state_d      = S_WALK;
            cnt_d        = '0;
            flush_pend_d = 1'b0;
        end
    end

    // State registers with synchronous reset into a fresh walk.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_WALK;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            init_done_q  <= 1'b0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            init_done_q  <= init_done_d;
            rvalid_q     <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_sram_cache_front.sv
// Bench for sram_cache_front with NUM_WORDS=16 and a behavioural SRAM.
// Inputs are applied on the falling edge; outputs are checked 1 ns later.
module tb_sram_cache_front;

  localparam int DW = 64;
  localparam int UW = 1;
  localparam int NW = 16;
  localparam int AW = 4;
  localparam int BW = 8;
  localparam logic [DW-1:0] INIT = 64'h0123_4567_89AB_CDEE;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_i, flush_i, cl_req_i, cl_we_i;
  logic [AW-1:0] cl_addr_i;
  logic [DW-1:0] cl_wdata_i;
  logic [BW-1:0] cl_be_i;
  logic          busy_o, init_done_o, cl_gnt_o, cl_rvalid_o;
  logic [DW-1:0] cl_rdata_o;
  logic          sram_req_o, sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [UW-1:0] sram_wuser_o, sram_ruser_i;
  logic [DW-1:0] sram_wdata_o, sram_rdata_i;
  logic [BW-1:0] sram_be_o;
`ifdef SRAM_CACHE_FRONT_PARITY_EN
  logic          par_err_o;
`endif

  sram_cache_front #(
    .DATA_WIDTH(DW), .USER_WIDTH(UW), .NUM_WORDS(NW), .INIT_VALUE(INIT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .busy_o(busy_o),
    .init_done_o(init_done_o), .cl_req_i(cl_req_i), .cl_gnt_o(cl_gnt_o),
    .cl_we_i(cl_we_i), .cl_addr_i(cl_addr_i), .cl_wdata_i(cl_wdata_i),
    .cl_be_i(cl_be_i), .cl_rvalid_o(cl_rvalid_o), .cl_rdata_o(cl_rdata_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wuser_o(sram_wuser_o), .sram_wdata_o(sram_wdata_o),
    .sram_be_o(sram_be_o),
`ifdef SRAM_CACHE_FRONT_PARITY_EN
    .par_err_o(par_err_o),
`endif
    .sram_ruser_i(sram_ruser_i), .sram_rdata_i(sram_rdata_i)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < BW; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // ---------------- behavioural SRAM (1-cycle read latency) ----------------
  logic [DW-1:0] sram_mem [NW];
  logic [UW-1:0] sram_umem [NW];
  logic [DW-1:0] sram_rdata_q;
  logic [UW-1:0] sram_ruser_q;
  logic          ruser_flip;

  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) begin
        sram_mem[sram_addr_o]  <= merge(sram_mem[sram_addr_o], sram_wdata_o, sram_be_o);
        sram_umem[sram_addr_o] <= sram_wuser_o;
      end else begin
        sram_rdata_q <= sram_mem[sram_addr_o];
        sram_ruser_q <= sram_umem[sram_addr_o];
      end
    end
  end
  assign sram_rdata_i = sram_rdata_q;
  assign sram_ruser_i = ruser_flip ? ~sram_ruser_q : sram_ruser_q;

  // ---------------- scoreboard ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ref_mem [NW];
  logic          exp_rv = 1'b0;

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic rst, input logic flush, input logic req,
                      input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [BW-1:0] be,
                      input logic e_gnt, input logic e_busy, input logic e_done);
    logic [DW-1:0] d;
    @(negedge clk_i);
    rst_i = rst; flush_i = flush; cl_req_i = req; cl_we_i = we;
    cl_addr_i = addr; cl_wdata_i = wdata; cl_be_i = be;
    #1;
    chk1("gnt", cl_gnt_o, e_gnt);
    chk1("busy", busy_o, e_busy);
    chk1("init_done", init_done_o, e_done);
    chk1("rvalid", cl_rvalid_o, exp_rv && !rst);
    if (exp_rv) begin
      d = exp_q.pop_front();
      if (!rst && cl_rvalid_o) chkd("rdata", cl_rdata_o, d);
    end
    exp_rv = 1'b0;
    if (rst || (!e_busy && !e_gnt)) chk1("sram_req_off", sram_req_o, 1'b0);
    if (e_gnt) begin
      chk1("sram_req_cl", sram_req_o, 1'b1);
      chk1("sram_we_cl", sram_we_o, we);
      chkd("sram_addr_cl", DW'(sram_addr_o), DW'(addr));
      if (we) begin
        chkd("sram_wdata_cl", sram_wdata_o, wdata);
        chkd("sram_be_cl", DW'(sram_be_o), DW'(be));
`ifdef SRAM_CACHE_FRONT_PARITY_EN
        chk1("sram_wuser_cl", sram_wuser_o[0], ^(wdata & {{8{be[7]}}, {8{be[6]}}, {8{be[5]}},
             {8{be[4]}}, {8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}}));
`else
        chk1("sram_wuser_cl", sram_wuser_o[0], 1'b0);
`endif
        ref_mem[addr] = merge(ref_mem[addr], wdata, be);
      end else begin
        exp_q.push_back(ref_mem[addr]);
        exp_rv = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic req, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    step(1'b0, 1'b0, req, we, addr, wdata, be, req, 1'b0, 1'b1);
  endtask

  // Walk cycles first..last; client requests are random and must be refused.
  task automatic walk(input int first, input int last, input int flush_at, input logic e_done);
    for (int i = first; i <= last; i++) begin
      step(1'b0, i == flush_at, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, NW - 1)), {$urandom(), $urandom()}, BW'($urandom()),
           1'b0, 1'b1, e_done);
      chk1("walk_req", sram_req_o, 1'b1);
      chk1("walk_we", sram_we_o, 1'b1);
      chkd("walk_addr", DW'(sram_addr_o), DW'(i));
      chkd("walk_wdata", sram_wdata_o, INIT);
      chkd("walk_be", DW'(sram_be_o), DW'(8'hFF));
`ifdef SRAM_CACHE_FRONT_PARITY_EN
      chk1("walk_wuser", sram_wuser_o[0], ^INIT);
`else
      chk1("walk_wuser", sram_wuser_o[0], 1'b0);
`endif
      ref_mem[i] = INIT;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_i = 1'b1; flush_i = 1'b0; cl_req_i = 1'b0; cl_we_i = 1'b0;
    cl_addr_i = '0; cl_wdata_i = '0; cl_be_i = '0; ruser_flip = 1'b0;
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;

    // Reset: requests refused, SRAM quiet, busy high.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, '0, '1, 1'b0, 1'b1, 1'b0);

    // First walk: 16 cycles, then init_done rises / busy falls.
    walk(0, NW - 1, -1, 1'b0);
    idle(1'b0, 1'b0, 4'd0, '0, '0);

    // Write then read address 5; write gives no rvalid.
    idle(1'b1, 1'b1, 4'd5, 64'hA5A5_0000_1234_5678, 8'hFF);
    idle(1'b1, 1'b0, 4'd5, '0, '0);
    idle(1'b0, 1'b0, 4'd0, '0, '0);
    idle(1'b0, 1'b0, 4'd0, '0, '0);

    // Random back-to-back traffic with partial byte enables.
    for (int i = 0; i < 150; i++) begin
      idle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, NW - 1)),
           {$urandom(), $urandom()}, BW'($urandom_range(0, 255)));
    end

    // Flush coincident with a request: flush wins, walk follows.
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, '0, '1, 1'b0, 1'b0, 1'b1);
    walk(0, NW - 1, -1, 1'b1);
    idle(1'b1, 1'b0, 4'd5, '0, '0);
    idle(1'b0, 1'b0, 4'd0, '0, '0);

    // Flush during a walk at address 7 chains a second full walk.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, '0, '0, 1'b0, 1'b0, 1'b1);
    walk(0, NW - 1, 7, 1'b1);
    walk(0, NW - 1, -1, 1'b1);
    idle(1'b1, 1'b1, 4'd9, 64'hFFFF_0000_FFFF_0000, 8'h0F);

    // Reset while a read is outstanding drops the rvalid.
    idle(1'b1, 1'b0, 4'd9, '0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd9, '0, '0, 1'b0, 1'b1, 1'b0);
    walk(0, NW - 1, -1, 1'b0);

    // Reset at walk address 10 restarts the walk and clears init_done.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, '0, '0, 1'b0, 1'b0, 1'b1);
    walk(0, 9, -1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, '0, '0, 1'b0, 1'b1, 1'b0);
    walk(0, NW - 1, -1, 1'b0);
    idle(1'b1, 1'b0, 4'd9, '0, '0);
    idle(1'b0, 1'b0, 4'd0, '0, '0);

`ifdef SRAM_CACHE_FRONT_PARITY_EN
    // Parity: corrupted user bit flags one pulse aligned with rvalid.
    idle(1'b1, 1'b1, 4'd3, 64'h1, 8'hFF);
    chk1("par_wuser_one", sram_wuser_o[0], 1'b1);
    idle(1'b1, 1'b0, 4'd3, '0, '0);
    ruser_flip = 1'b1;
    idle(1'b0, 1'b0, 4'd0, '0, '0);
    chk1("par_err_forced", par_err_o, 1'b1);
    ruser_flip = 1'b0;
    idle(1'b0, 1'b0, 4'd0, '0, '0);
    chk1("par_err_pulse_end", par_err_o, 1'b0);
    idle(1'b1, 1'b0, 4'd3, '0, '0);
    idle(1'b0, 1'b0, 4'd0, '0, '0);
    chk1("par_err_clean", par_err_o, 1'b0);
`endif

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_cache_front.md
Name: sram_cache_front

Overview:
- Request front-end placed directly upstream of one sram_cache instance (one cache data or tag array).
- Owns the array after reset and on flush: walks every word and writes INIT_VALUE.
- Outside a walk, forwards single client requests to the SRAM with a grant handshake.
- Returns read data with a valid strobe aligned to the 1-cycle SRAM latency.

Parameters:
- DATA_WIDTH, 64, SRAM data width.
- USER_WIDTH, 1, SRAM user sideband width; must be >=1.
- NUM_WORDS, 1024, array depth; power of two, >=2.
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every word during a walk.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- flush_i  in  1  request a full-array re-initialisation walk
- busy_o  out  1  a walk is in progress
- init_done_o  out  1  first post-reset walk completed; stays set until the next reset
- cl_req_i  in  1  client request
- cl_gnt_o  out  1  request accepted this cycle
- cl_we_i  in  1  1 = write, 0 = read
- cl_addr_i  in  $clog2(NUM_WORDS)  client word address
- cl_wdata_i  in  DATA_WIDTH  client write data
- cl_be_i  in  (DATA_WIDTH+7)/8  client byte enables
- cl_rvalid_o  out  1  read data valid
- cl_rdata_o  out  DATA_WIDTH  read data
- sram_req_o  out  1  to sram_cache req_i
- sram_we_o  out  1  to sram_cache we_i
- sram_addr_o  out  $clog2(NUM_WORDS)  to sram_cache addr_i
- sram_wuser_o  out  USER_WIDTH  to sram_cache wuser_i
- sram_wdata_o  out  DATA_WIDTH  to sram_cache wdata_i
- sram_be_o  out  (DATA_WIDTH+7)/8  to sram_cache be_i
- sram_ruser_i  in  USER_WIDTH  from sram_cache ruser_o
- sram_rdata_i  in  DATA_WIDTH  from sram_cache rdata_o
- par_err_o  out  1  read parity error; present only with the optional feature

Behaviour:
- Reset:
  - State register = WALK; walk counter = 0; flush_pend = 0.
  - init_done_o = 0; cl_rvalid_o = 0; cl_gnt_o = 0; busy_o = 1.
  - sram_req_o is forced 0 while rst_i is high.
- States: WALK, IDLE.
- WALK:
  - Each cycle drives sram_req_o=1, sram_we_o=1, sram_addr_o=counter, sram_wdata_o=INIT_VALUE, sram_be_o=all ones, sram_wuser_o=0.
  - The counter increments by 1 each cycle.
  - At counter==NUM_WORDS-1 the counter wraps to 0, init_done_o is set, and the state goes to IDLE next cycle.
  - A walk therefore takes exactly NUM_WORDS cycles.
  - cl_gnt_o=0 throughout; busy_o=1.
- flush_i during WALK sets flush_pend. The current walk is not restarted. On completion the state returns to WALK, not IDLE, and flush_pend clears.
- IDLE:
  - busy_o=0.
  - If flush_i or flush_pend is set, go to WALK next cycle; cl_gnt_o=0 this cycle, so flush wins over a coincident client request.
  - Otherwise cl_gnt_o = cl_req_i, combinational.
  - The sram_* outputs mirror the client fields when granted. sram_req_o = cl_gnt_o.
- Reads:
  - A granted read (cl_we_i=0) sets cl_rvalid_o exactly one cycle later for one cycle.
  - cl_rdata_o = sram_rdata_i, combinational; don't-care when cl_rvalid_o=0.
  - Writes never produce cl_rvalid_o.
- Back-to-back grants are allowed every cycle. Throughput is 1 request per cycle; read latency is 1 cycle.
- A read granted in the last IDLE cycle before a walk still returns cl_rvalid_o in the first WALK cycle.
- Reset asserted mid-walk or mid-read:
  - Restarts WALK at address 0 and clears init_done_o.
  - A pending cl_rvalid_o is dropped.

Optional Feature:
- Macro: SRAM_CACHE_FRONT_PARITY_EN.
- Defined:
  - On writes, sram_wuser_o[0] = even parity (XOR) of the bytes selected by the byte enables. The walk writes the parity of INIT_VALUE.
  - On cl_rvalid_o, par_err_o = XOR(sram_rdata_i) ^ sram_ruser_i[0], one-cycle pulse, 0 at reset.
  - The downstream sram_cache must be built with USER_EN=1.
  - Partial-byte-enable writes make the parity valid only for fully written words; the bench uses full enables for parity checks.
- Undefined:
  - par_err_o port is absent.
  - sram_wuser_o = 0; sram_ruser_i is ignored.

Test Plan:
- NUM_WORDS=16: release rst_i -> sram_req_o/we_o=1 with addresses 0..15 on 16 consecutive cycles, data INIT_VALUE, be all ones. init_done_o rises and busy_o falls on cycle 17. cl_gnt_o=0 throughout.
- After init: write addr 5 data 0xA5A5_0000_1234_5678 be=0xFF, next cycle read addr 5 -> cl_gnt_o=1 both cycles. cl_rvalid_o=1 one cycle after the read grant with that data. No rvalid after the write.
- flush_i and cl_req_i high in the same IDLE cycle -> cl_gnt_o=0, walk of 16 cycles begins next cycle. Read addr 5 afterwards returns INIT_VALUE.
- flush_i pulsed at walk address 7 -> walk completes to 15, then a second full 16-cycle walk runs, then IDLE.
- rst_i asserted for 1 cycle at walk address 10 -> sram_req_o=0 that cycle, walk restarts at 0, init_done_o=0 until completion.
- With SRAM_CACHE_FRONT_PARITY_EN: write 0x01 full be (wuser=1), then force sram_ruser_i[0]=0 on the read -> par_err_o=1 for one cycle aligned with cl_rvalid_o. An unforced read gives par_err_o=0.
